// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM encoding, datapath defaults and flag positions.
// Used by the multicycle subtractor and the adder path.
package alu_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DIGIT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    localparam int BOUT   = 0;
    localparam int OVF    = 1;
    localparam int ZERO   = 2;
    localparam int FLAG_W = 3;

endpackage

// File: rtl/sub_digit.sv
// One digit of the serial subtractor: combinational borrow-ripple
// chain of full-subtractor cells, x - y - bi.
module sub_digit #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] diff,
    output logic               bo
);

    logic [DIGIT_W:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
        assign diff[i]  = x[i] ^ y[i] ^ br[i];
        assign br[i+1]  = (~x[i] & y[i])
                        | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bo = br[DIGIT_W];

endmodule

// File: rtl/sub_16_seq.sv
// Multicycle subtractor: a - b - bin, one digit per clock, LSB first.
// Results and flags hold until the next accepted start.
module sub_16_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIGIT_W = DEF_DIGIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t state;
    state_t nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   xa;
    logic [WIDTH-1:0]   xb;
    logic [WIDTH-1:0]   acc;
    logic               brw;
    logic [WIDTH-1:0]   d_r;
    logic [FLAG_W-1:0]  flags;
    logic               done_r;

    logic [DIGIT_W-1:0] dig;
    logic               dig_bo;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   res;

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .x    (xa[DIGIT_W-1:0]),
        .y    (xb[DIGIT_W-1:0]),
        .bi   (brw),
        .diff (dig),
        .bo   (dig_bo)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(N - 1));
    // New digit enters at the top; after N digits the word is aligned.
    assign res    = WIDTH'({dig, acc} >> DIGIT_W);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last)  nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            xa     <= '0;
            xb     <= '0;
            acc    <= '0;
            brw    <= 1'b0;
            d_r    <= '0;
            flags  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= last;
            if (accept) begin
                xa  <= a;
                xb  <= b;
                brw <= bin;
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                xa  <= xa >> DIGIT_W;
                xb  <= xb >> DIGIT_W;
                brw <= dig_bo;
                acc <= res;
                cnt <= cnt + 1'b1;
                if (last) begin
                    // Top digit of xa/xb still holds the operand sign bits.
                    d_r         <= res;
                    flags[BOUT] <= dig_bo;
                    flags[OVF]  <= (xa[DIGIT_W-1] != xb[DIGIT_W-1])
                                && (res[WIDTH-1] != xa[DIGIT_W-1]);
                    flags[ZERO] <= (res == '0);
                end
            end
        end
    end

    assign d    = d_r;
    assign bout = flags[BOUT];
    assign ovf  = flags[OVF];
    assign zero = flags[ZERO];
    assign busy = (state == RUN);
    assign done = done_r;

endmodule

// File: tb/tb_sub_16_seq.sv
// Directed and randomised checks of the multicycle subtractor.
module tb_sub_16_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
    logic        busy;
    logic        done;

    int nchk = 0;
    int nerr = 0;

    sub_16_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ends at the negedge right after the accepting edge.
    task automatic start_op(input logic [15:0] ia,
                            input logic [15:0] ib,
                            input logic        ibin);
        @(negedge clk);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 20 && !done) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic go(input logic [15:0] ia,
                      input logic [15:0] ib,
                      input logic        ibin,
                      input logic [15:0] ed,
                      input logic        eb,
                      input logic        eo,
                      input logic        ez);
        int lat;
        start_op(ia, ib, ibin);
        check("busy", busy, 1);
        wait_done(lat);
        check("lat", lat, 4);
        check("d", d, ed);
        check("bout", bout, eb);
        check("ovf", ovf, eo);
        check("zero", zero, ez);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("d_hold", d, ed);
    endtask

    initial begin
        int          lat;
        int          tot;
        logic [16:0] r;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;
        logic        ro;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_d", d, 0);
        check("rst_flags", {bout, ovf, zero}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        go(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
        go(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
        go(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, 0);
        go(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, 0);
        go(16'h0005, 16'h0004, 1, 16'h0000, 0, 0, 1);
        go(16'hABCD, 16'hABCD, 1, 16'hFFFF, 1, 0, 0);

        // Start while busy must be ignored.
        start_op(16'h1111, 16'h0011, 0);
        @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ign", busy, 1);
        wait_done(lat);
        check("lat_ign", lat + 2, 4);
        check("d_ign", d, 16'h1100);
        // Start during the done cycle is accepted.
        a     = 16'h0003;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("b2b_gap", lat + 1, 5);
        check("d_b2b", d, 16'h0002);

        // Reset in the middle of a run.
        start_op(16'h4444, 16'h1111, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_d", d, 0);
        check("mrst_flags", {bout, ovf, zero}, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        go(16'h4444, 16'h1111, 0, 16'h3333, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
            ro   = (ra[15] != rb[15]) && (r[15] != ra[15]);
            start_op(ra, rb, rbin);
            wait_done(tot);
            check("rnd_lat", tot, 4);
            check("rnd_d", d, r[15:0]);
            check("rnd_bout", bout, r[16]);
            check("rnd_ovf", ovf, ro);
            check("rnd_zero", zero, r[15:0] == 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
